// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch (I) and load/store (D) ports onto one single-port memory
// with a fixed read latency. D has priority; a starvation counter forces I through.
module mem_port_arbiter #(
  parameter int MEM_LAT      = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        m_en,
  output logic        m_we,
  output logic [3:0]  m_be,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  output logic        busy,
  output logic [1:0]  owner
);
  localparam int              SW         = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0]   STARVE_MAX = SW'(STARVE_LIMIT);
  localparam bit              STARVE_EN  = (STARVE_LIMIT != 0);
  localparam logic [3:0]      LAT        = 4'(MEM_LAT);
  localparam logic [1:0]      OWN_NONE   = 2'b00;
  localparam logic [1:0]      OWN_I      = 2'b01;
  localparam logic [1:0]      OWN_D      = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [3:0]    r_cnt;
  logic [SW-1:0] r_starve;
  logic [1:0]    r_owner;
  logic          w_force_i;
  logic          w_grant_i;
  logic          w_grant_d;

  assign w_force_i = STARVE_EN && (r_starve == STARVE_MAX);
  assign w_grant_i = i_req && (!d_req || w_force_i);
  assign w_grant_d = d_req && !w_grant_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (i_req || d_req) w_state_next = S_ISSUE;
      S_ISSUE: w_state_next = S_WAIT;
      S_WAIT:  if (r_cnt == 4'd1) w_state_next = S_RESP;
      S_RESP:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    m_en  = 1'b0;
    i_ack = 1'b0;
    d_ack = 1'b0;
    case (r_state)
      S_ISSUE: m_en = 1'b1;
      S_RESP: begin
        i_ack = (r_owner == OWN_I);
        d_ack = (r_owner == OWN_D);
      end
      default: ;
    endcase
  end

  assign busy  = (r_state != S_IDLE);
  assign owner = r_owner;

  // Memory-side fields are latched at grant and simply held until the next grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_starve <= '0;
      r_owner  <= OWN_NONE;
      m_we     <= 1'b0;
      m_be     <= '0;
      m_addr   <= '0;
      m_wdata  <= '0;
      i_rdata  <= '0;
      d_rdata  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!i_req) r_starve <= '0;
          if (w_grant_i) begin
            r_owner  <= OWN_I;
            m_addr   <= i_addr;
            m_we     <= 1'b0;
            m_be     <= '0;
            m_wdata  <= '0;
            r_starve <= '0;
          end else if (w_grant_d) begin
            r_owner <= OWN_D;
            m_addr  <= d_addr;
            m_we    <= d_we;
            m_be    <= d_be;
            m_wdata <= d_wdata;
            if (i_req && (r_starve != STARVE_MAX)) r_starve <= r_starve + 1'b1;
          end
        end
        S_ISSUE: r_cnt <= LAT;
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          // cnt==1 is the cycle in which m_rdata for this access is valid
          if (r_cnt == 4'd1) begin
            if (r_owner == OWN_I) begin
              i_rdata <= m_rdata;
            end else if (!m_we) begin
              d_rdata <= m_rdata;
            end
          end
        end
        S_RESP:  r_owner <= OWN_NONE;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations, then
// random traffic checked every cycle against a transaction-timing model.
module tb_mem_port_arbiter;
  localparam int LAT = 3;
  localparam int SL  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        m_en;
  logic        m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata = 32'h0;
  logic        busy;
  logic [1:0]  owner;

  mem_port_arbiter #(.MEM_LAT(LAT), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .m_en(m_en), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h40) return 32'h00500093;
    return (a * 32'h9E3779B1) ^ 32'h12345678;
  endfunction

  // Memory: data valid only in the cycle exactly LAT after m_en, noise otherwise.
  int          mem_due = -1;
  logic [31:0] mem_data = 32'h0;
  always @(negedge clk) begin
    if (cyc == mem_due) m_rdata <= mem_data;
    else                m_rdata <= $urandom;
    if (m_en === 1'b1) begin
      mem_due  <= cyc + LAT;
      mem_data <= mem_word(m_addr);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // Model: a granted transaction issues at t+1 and acks at t+LAT+2.
  bit          m_valid = 1'b0;
  bit          m_act = 1'b0;
  int          m_t = 0;
  logic [1:0]  m_own = 2'b00;
  logic [31:0] m_laddr = 0, m_lwdata = 0;
  logic        m_lwe = 0;
  logic [3:0]  m_lbe = 0;
  int          m_starve = 0;
  logic [31:0] e_addr = 0, e_wdata = 0, e_i_rdata = 0, e_d_rdata = 0;
  logic        e_we = 0;
  logic [3:0]  e_be = 0;
  bit          e_wd_known = 1'b1;
  logic        saw_i_ack = 1'b0, saw_d_ack = 1'b0;
  int          grants[$];

  task automatic model_cycle();
    int         c;
    logic       e_en, e_fin;
    logic [1:0] e_own;
    c = cyc;
    if (m_valid) begin
      if (m_act && c > m_t + LAT + 2) m_act = 1'b0;
      e_en  = m_act && (c == m_t + 1);
      e_fin = m_act && (c == m_t + LAT + 2);
      e_own = m_act ? m_own : 2'b00;
      if (e_en) begin
        e_addr = m_laddr; e_we = m_lwe; e_be = m_lbe;
        e_wd_known = (m_own == 2'b10);
        if (m_own == 2'b10) e_wdata = m_lwdata;
        grants.push_back(int'(m_own));
      end
      if (e_fin && !m_lwe) begin
        if (m_own == 2'b01) e_i_rdata = mem_word(m_laddr);
        else                e_d_rdata = mem_word(m_laddr);
      end
      chk("busy", 32'(busy), 32'(m_act));
      chk("owner", 32'(owner), 32'(e_own));
      chk("m_en", 32'(m_en), 32'(e_en));
      chk("i_ack", 32'(i_ack), 32'(e_fin && m_own == 2'b01));
      chk("d_ack", 32'(d_ack), 32'(e_fin && m_own == 2'b10));
      chk("m_addr", m_addr, e_addr);
      chk("m_we", 32'(m_we), 32'(e_we));
      chk("m_be", 32'(m_be), 32'(e_be));
      if (e_wd_known) chk("m_wdata", m_wdata, e_wdata);
      chk("i_rdata", i_rdata, e_i_rdata);
      chk("d_rdata", d_rdata, e_d_rdata);
      if (e_fin)
        $display("txn cyc=%0d port=%s addr=%h we=%0d be=%h rdata_i=%h rdata_d=%h",
                 c, (m_own == 2'b01) ? "I" : "D", m_laddr, m_lwe, m_lbe, i_rdata, d_rdata);
    end
    saw_i_ack = i_ack;
    saw_d_ack = d_ack;
    if (rst) begin
      m_valid = 1'b1; m_act = 1'b0; m_starve = 0;
      e_addr = 0; e_wdata = 0; e_we = 0; e_be = 0; e_wd_known = 1'b1;
      e_i_rdata = 0; e_d_rdata = 0;
    end else if (m_valid && !m_act) begin
      if (!i_req) m_starve = 0;
      if (i_req || d_req) begin
        m_act = 1'b1;
        m_t   = c;
        if (i_req && (!d_req || (SL != 0 && m_starve == SL))) begin
          m_own = 2'b01; m_laddr = i_addr; m_lwe = 1'b0; m_lbe = 4'h0; m_starve = 0;
        end else begin
          m_own = 2'b10; m_laddr = d_addr; m_lwe = d_we; m_lbe = d_be; m_lwdata = d_wdata;
          if (i_req && m_starve < SL) m_starve++;
        end
      end
    end
  endtask

  task automatic wait_txn(input bit port_d, output int en_at, output int ack_at,
                          output logic [31:0] a_at, output logic [31:0] wd_at,
                          output logic we_at, output logic [3:0] be_at);
    en_at = -1; ack_at = -1; a_at = 0; wd_at = 0; we_at = 0; be_at = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (m_en === 1'b1 && en_at < 0) begin
        en_at = cyc; a_at = m_addr; wd_at = m_wdata; we_at = m_we; be_at = m_be;
      end
      if ((port_d ? d_ack : i_ack) === 1'b1) begin
        ack_at = cyc;
        break;
      end
    end
    chk("wait_ack_in_time", 32'(ack_at >= 0), 32'd1);
  endtask

  initial begin
    int          t0, en_at, ack_at, g0, n_ack;
    logic [31:0] a_at, wd_at;
    logic        we_at;
    logic [3:0]  be_at;
    int          exp3[6];
    exp3 = '{2, 2, 2, 2, 1, 2};

    rst = 1'b1; i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_be = 0; d_addr = 0; d_wdata = 0;
    fork
      forever begin
        @(negedge clk);
        model_cycle();
      end
    join_none
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_i_rdata", i_rdata, 32'd0);

    // Single fetch: m_en at t+1, i_ack at t+5 with MEM_LAT=3
    @(posedge clk); #1 i_req = 1; i_addr = 32'h40; t0 = cyc;
    wait_txn(1'b0, en_at, ack_at, a_at, wd_at, we_at, be_at);
    chk("t1_en_lat", en_at - t0, 32'd1);
    chk("t1_ack_lat", ack_at - t0, 32'd5);
    chk("t1_rdata", i_rdata, 32'h00500093);
    chk("t1_owner_at_ack", 32'(owner), 32'd1);
    @(posedge clk); #1 i_req = 0;
    @(negedge clk);
    chk("t1_owner_after", 32'(owner), 32'd0);

    // Simultaneous requests: D first, then I
    @(posedge clk); #1;
    d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h100; i_req = 1; i_addr = 32'h44; t0 = cyc;
    wait_txn(1'b1, en_at, ack_at, a_at, wd_at, we_at, be_at);
    chk("t2_d_en", en_at - t0, 32'd1);
    chk("t2_d_ack", ack_at - t0, 32'd5);
    chk("t2_d_addr", a_at, 32'h100);
    @(posedge clk); #1 d_req = 0;
    wait_txn(1'b0, en_at, ack_at, a_at, wd_at, we_at, be_at);
    chk("t2_i_en", en_at - t0, 32'd7);
    chk("t2_i_ack", ack_at - t0, 32'd11);
    @(posedge clk); #1 i_req = 0;

    // Starvation: back-to-back D loads with I pending
    g0 = grants.size();
    @(posedge clk); #1;
    i_req = 1; i_addr = 32'h300; d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h400;
    for (int k = 0; k < 100 && grants.size() < g0 + 6; k++) begin
      @(posedge clk); #1;
      if (saw_i_ack) i_req = 0;
      if (saw_d_ack) d_addr = d_addr + 32'd4;
    end
    wait_txn(1'b1, en_at, ack_at, a_at, wd_at, we_at, be_at);
    @(posedge clk); #1 d_req = 0; i_req = 0;
    for (int j = 0; j < 6; j++) chk("t3_grant_order", grants[g0 + j], exp3[j]);
    chk("t3_d_rdata", d_rdata, mem_word(32'h410));
    @(negedge clk);
    chk("t3_starve_cleared", m_starve, 32'd0);

    // Store with partial byte enables
    @(posedge clk); #1;
    d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 32'h200; d_wdata = 32'hDEADBEEF; t0 = cyc;
    wait_txn(1'b1, en_at, ack_at, a_at, wd_at, we_at, be_at);
    chk("t4_m_we", 32'(we_at), 32'd1);
    chk("t4_m_be", 32'(be_at), 32'h3);
    chk("t4_m_addr", a_at, 32'h200);
    chk("t4_m_wdata", wd_at, 32'hDEADBEEF);
    chk("t4_ack_lat", ack_at - t0, 32'd5);
    chk("t4_d_rdata_kept", d_rdata, mem_word(32'h410));
    @(posedge clk); #1 d_req = 0; d_we = 0;

    // Reset during WAIT drops the access
    @(posedge clk); #1 i_req = 1; i_addr = 32'h80;
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1; i_req = 0;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_owner", 32'(owner), 32'd0);
    chk("t6_i_rdata", i_rdata, 32'd0);
    n_ack = 0;
    repeat (10) begin
      @(negedge clk);
      if (i_ack === 1'b1) n_ack++;
    end
    chk("t6_no_ack", n_ack, 32'd0);
    @(posedge clk); #1 i_req = 1; i_addr = 32'h40; t0 = cyc;
    wait_txn(1'b0, en_at, ack_at, a_at, wd_at, we_at, be_at);
    chk("t6_fresh_en", en_at - t0, 32'd1);
    chk("t6_fresh_ack", ack_at - t0, 32'd5);
    chk("t6_fresh_rdata", i_rdata, 32'h00500093);
    @(posedge clk); #1 i_req = 0;

    // Random traffic with occasional resets
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk); #1;
      rst = ($urandom_range(0, 199) == 0);
      if (i_req && saw_i_ack) begin
        if ($urandom_range(0, 1) == 1) i_addr = $urandom;
        else i_req = 0;
      end else if (!i_req && $urandom_range(0, 3) == 0) begin
        i_req = 1; i_addr = $urandom;
      end
      if (d_req && saw_d_ack) begin
        if ($urandom_range(0, 1) == 1) begin
          d_we = 1'($urandom_range(0, 1)); d_be = 4'($urandom_range(0, 15));
          d_addr = $urandom; d_wdata = $urandom;
        end else d_req = 0;
      end else if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1; d_we = 1'($urandom_range(0, 1)); d_be = 4'($urandom_range(0, 15));
        d_addr = $urandom; d_wdata = $urandom;
      end
    end
    @(posedge clk); #1 rst = 0; i_req = 0; d_req = 0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
